// File: rtl/ir_rx_nec_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ir_rx_nec_param                                                          |
// | NEC IR frame receiver: 1 us tick, windowed mark/space timing, checksum.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ir_rx_nec_param #(
    parameter int CLK_HZ     = 50000000,
    parameter bit RX_INV     = 1'b1,
    parameter bit CHECK_EN   = 1'b1,
    parameter bit EXT_ADDR   = 1'b0,
    parameter int TIMEOUT_US = 12000,
    parameter int TOL_US     = 300
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_ir_rxb,
    output logic [31:0] o_data,
    output logic        o_valid,
    output logic        o_repeat,
    output logic        o_err,
    output logic [1:0]  o_err_code,
    output logic        o_busy
);
    localparam int DIV_RAW = CLK_HZ / 1000000;
    localparam int DIV     = (DIV_RAW < 2) ? 2 : DIV_RAW;
    localparam int TW      = $clog2(DIV);

    typedef enum logic [2:0] {
        S_IDLE, S_LEAD_MARK, S_LEAD_SPACE, S_DATA_MARK,
        S_DATA_SPACE, S_STOP_MARK, S_CHECK, S_RPT_MARK
    } state_t;

    function automatic logic in_win(input logic [15:0] d, input int nom);
        int v;
        v = int'(d);
        return (v >= nom - TOL_US) && (v <= nom + TOL_US);
    endfunction

    logic          w_pin, w_rise, w_fall, w_tick, w_timeout, w_ck_ok;
    logic          w_win_lead, w_win_hdr, w_win_rpt, w_win_short, w_win_long;
    logic          sync1_q, sync2_q, prev_q;
    logic [TW-1:0] tick_cnt_q;
    logic [15:0]   dur_q;
    state_t        state_q, state_d;
    logic [31:0]   shreg_q, shreg_d, data_q, data_d;
    logic [5:0]    bit_cnt_q, bit_cnt_d;
    logic          have_q, have_d;
    logic          valid_q, valid_d, rep_q, rep_d, err_q, err_d;
    logic [1:0]    code_q, code_d;

    assign w_pin  = RX_INV ? ~i_ir_rxb : i_ir_rxb;
    assign w_rise = sync2_q & ~prev_q;
    assign w_fall = ~sync2_q & prev_q;
    assign w_tick = (tick_cnt_q == TW'(DIV - 1));

    assign w_win_lead  = in_win(dur_q, 9000);
    assign w_win_hdr   = in_win(dur_q, 4500);
    assign w_win_rpt   = in_win(dur_q, 2250);
    assign w_win_short = in_win(dur_q, 560);
    assign w_win_long  = in_win(dur_q, 1690);
    assign w_timeout   = (int'(dur_q) > TIMEOUT_US);

    assign w_ck_ok = !CHECK_EN ||
                     ((shreg_q[31:24] == ~shreg_q[23:16]) &&
                      (EXT_ADDR || (shreg_q[15:8] == ~shreg_q[7:0])));

    always_ff @(posedge clk) begin
        if (rst_n) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            prev_q     <= 1'b0;
            tick_cnt_q <= '0;
            dur_q      <= '0;
        end else begin
            sync1_q    <= w_pin;
            sync2_q    <= sync1_q;
            prev_q     <= sync2_q;
            tick_cnt_q <= w_tick ? '0 : tick_cnt_q + 1'b1;
            // Duration is measured from the last edge strobe and saturates.
            if (w_rise || w_fall)
                dur_q <= '0;
            else if (w_tick && (dur_q != 16'hFFFF))
                dur_q <= dur_q + 16'd1;
        end
    end

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        data_d    = data_q;
        have_d    = have_q;
        code_d    = code_q;
        valid_d   = 1'b0;
        rep_d     = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            S_IDLE: if (w_rise) state_d = S_LEAD_MARK;
            S_LEAD_MARK: if (w_fall) begin
                if (w_win_lead) state_d = S_LEAD_SPACE;
                else begin err_d = 1'b1; code_d = 2'd0; state_d = S_IDLE; end
            end
            S_LEAD_SPACE: if (w_rise) begin
                if (w_win_hdr) begin bit_cnt_d = '0; state_d = S_DATA_MARK; end
                else if (w_win_rpt) state_d = S_RPT_MARK;
                else begin err_d = 1'b1; code_d = 2'd0; state_d = S_IDLE; end
            end
            S_DATA_MARK: if (w_fall) begin
                if (w_win_short) state_d = S_DATA_SPACE;
                else begin err_d = 1'b1; code_d = 2'd0; state_d = S_IDLE; end
            end
            S_DATA_SPACE: if (w_rise) begin
                if (w_win_short || w_win_long) begin
                    shreg_d   = {~w_win_short, shreg_q[31:1]};
                    bit_cnt_d = bit_cnt_q + 6'd1;
                    state_d   = (bit_cnt_q == 6'd31) ? S_STOP_MARK : S_DATA_MARK;
                end else begin err_d = 1'b1; code_d = 2'd0; state_d = S_IDLE; end
            end
            S_STOP_MARK: if (w_fall) begin
                if (w_win_short) state_d = S_CHECK;
                else begin err_d = 1'b1; code_d = 2'd0; state_d = S_IDLE; end
            end
            S_CHECK: begin
                if (w_ck_ok) begin data_d = shreg_q; valid_d = 1'b1; have_d = 1'b1; end
                else begin err_d = 1'b1; code_d = 2'd2; end
                state_d = S_IDLE;
            end
            S_RPT_MARK: if (w_fall) begin
                if (w_win_short && have_q) rep_d = 1'b1;
                else if (w_win_short) begin err_d = 1'b1; code_d = 2'd3; end
                else begin err_d = 1'b1; code_d = 2'd0; end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // An edge in the same clock wins over an expiring duration.
        if ((state_q != S_IDLE) && (state_q != S_CHECK) && !w_rise && !w_fall && w_timeout) begin
            err_d   = 1'b1;
            code_d  = 2'd1;
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q   <= S_IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            data_q    <= '0;
            have_q    <= 1'b0;
            code_q    <= 2'd0;
            valid_q   <= 1'b0;
            rep_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            data_q    <= data_d;
            have_q    <= have_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            rep_q     <= rep_d;
            err_q     <= err_d;
        end
    end

    assign o_data     = data_q;
    assign o_valid    = valid_q;
    assign o_repeat   = rep_q;
    assign o_err      = err_q;
    assign o_err_code = code_q;
    assign o_busy     = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: doc/ir_rx_nec_param.md
Name: ir_rx_nec_param

Overview:
Parametrised NEC infrared frame receiver. It is the successor of the fixed 50 MHz IR receiver. It runs on the system clock with an internal 1 us tick enable (no derived clocks), measures every mark and space against tolerance windows, and decodes 32-bit frames and repeat codes. It validates the inverted-byte checksum and reports per-frame status pulses and error codes. It sits between the board IR pin and display/control logic.

Parameters:
CLK_HZ, 50000000, system clock frequency; tick divider = CLK_HZ/1000000, minimum 2
RX_INV, 1, 1 = IR pin idles high (module inverts it); 0 = pin already active-high
CHECK_EN, 1, 1 = enforce checksum; 0 = accept any 32-bit frame
EXT_ADDR, 0, 1 = extended NEC (address bytes not checked; command pair only)
TIMEOUT_US, 12000, maximum mark or space before abort
TOL_US, 300, +/- tolerance on every nominal duration

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous, active-high reset (asserted = 1; name kept for port-list consistency)
i_ir_rxb  in  1  raw IR receiver pin, asynchronous
o_data  out  32  last accepted frame; first received bit in o_data[0]
o_valid  out  1  one-clk pulse: new frame accepted into o_data
o_repeat  out  1  one-clk pulse: repeat code after a prior valid frame
o_err  out  1  one-clk pulse: frame aborted
o_err_code  out  2  cause of the last o_err: 0 timing, 1 timeout, 2 checksum, 3 repeat without frame
o_busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (rst_n=1 at posedge clk): all outputs 0, state IDLE, counters 0, have_frame flag 0, synchronizer flops 0 (after RX_INV). Reset mid-frame discards the partial frame without an o_err pulse.
- Input path: apply RX_INV, then 2-flop synchronizer, then 1-flop edge detector. Rise and fall are single-clk strobes, 3 clks after the pin change.
- Tick: counts 0..CLK_HZ/1e6-1 and pulses for 1 clk at wrap. Reset restarts it at 0.
- Duration counter: 16 bits, +1 per tick, saturates at 65535, cleared to 0 on every edge strobe. A window [N-TOL_US, N+TOL_US] is checked on the counter value at the edge.
- FSM (states and transitions):
  - IDLE: on rise go to LEAD_MARK.
  - LEAD_MARK: on fall, 9000 in window goes to LEAD_SPACE; otherwise timing error.
  - LEAD_SPACE: on rise, 4500 in window sets bit_cnt=0 and goes to DATA_MARK. 2250 in window goes to RPT_MARK. Otherwise timing error.
  - DATA_MARK: on fall, 560 in window goes to DATA_SPACE; otherwise timing error.
  - DATA_SPACE: on rise, 560 window shifts in 0 and 1690 window shifts in 1 (shift register LSB-first; bit_cnt 6 bits, +1). Otherwise timing error. If bit_cnt reaches 32 go to STOP_MARK, else DATA_MARK.
  - STOP_MARK: on fall, 560 in window goes to CHECK; otherwise timing error.
  - CHECK (1 clk): checksum ok = (byte3 == ~byte2) and (EXT_ADDR or byte1 == ~byte0), or CHECK_EN==0. If ok: o_data <= shift register, o_valid pulse, have_frame=1. Else o_err, code 2, o_data unchanged. Go to IDLE.
  - RPT_MARK: on fall, 560 in window and have_frame gives an o_repeat pulse (o_data unchanged). Window ok but !have_frame gives o_err code 3. Otherwise timing error. Go to IDLE.
- Timeout: in any non-IDLE state, counter > TIMEOUT_US gives o_err code 1 and IDLE. An edge in the same clk takes priority over timeout.
- A timing error gives o_err code 0 and IDLE. A rise arriving in that same clk is not re-evaluated; it waits for the next edge.
- o_valid, o_repeat, o_err are mutually exclusive and each is exactly 1 clk wide.
- Latency: o_valid asserts 1 clk after the synchronized stop-mark fall (CHECK state).
- o_err_code holds its value until the next o_err.

Test Plan:
- Nominal frame, addr 0x00, cmd 0x45, exact timings -> one o_valid pulse, o_data=32'hBA45FF00, o_err stays 0.
- Same frame with every duration +250 us, then a second copy at +350 us -> first gives o_valid; second gives o_err code 0 at the first out-of-window edge and o_data stays 0xBA45FF00.
- Repeat code (9000/2250/560) after a valid frame -> o_repeat pulse and o_data unchanged. The same repeat code right after reset -> o_err code 3.
- Frame with cmd 0x45 and byte3 0xBB, CHECK_EN=1 -> o_err code 2 and o_data unchanged. Rerun with CHECK_EN=0 -> o_valid, o_data=32'hBB45FF00.
- Pin stuck mid-frame after 10 bits for 13 ms -> o_err code 1 at TIMEOUT_US+1 ticks after the last edge, o_busy falls, and a following nominal frame decodes correctly.
- rst_n pulsed during bit 20, plus a CLK_HZ=25000000 build with the nominal frame -> no o_err after reset, all outputs 0, and the 25 MHz build decodes 0xBA45FF00.
